// File: rtl/cicero_cmd_pkg.sv
// Shared constants for the CICERO command controller: opcodes, FSM states,
// error codes and status word layout.
package cicero_cmd_pkg;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ERR_W  = 4;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_NOP        = 4'd0;
  localparam logic [OP_W-1:0] OP_WRITE      = 4'd1;
  localparam logic [OP_W-1:0] OP_READ       = 4'd2;
  localparam logic [OP_W-1:0] OP_START      = 4'd3;
  localparam logic [OP_W-1:0] OP_CORE_RESET = 4'd4;
  localparam logic [OP_W-1:0] OP_CLEAR_ERR  = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEM    = 4'd2,
    ST_START  = 4'd3,
    ST_DONE   = 4'd4
  } state_e;

  localparam logic [ERR_W-1:0] ERR_NONE          = 4'd0;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL       = 4'd1;
  localparam logic [ERR_W-1:0] ERR_MEM_TIMEOUT   = 4'd2;
  localparam logic [ERR_W-1:0] ERR_START_TIMEOUT = 4'd3;

  localparam int unsigned ST_TAG_LSB    = 24;
  localparam int unsigned ST_STATE_LSB  = 20;
  localparam int unsigned ST_ERR_LSB    = 16;
  localparam int unsigned ST_RUN_BIT    = 2;
  localparam int unsigned ST_STICKY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT   = 0;

endpackage

// File: rtl/cicero_cmd_ctrl_cdc_sync_bus.sv
// Parameterized-width two-flop synchronizer for quasi-static buses.
module cdc_sync_bus #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cicero_cmd_ctrl.sv
// CICERO command controller: synchronizes JTAG-side registers, decodes tagged
// commands and drives the instruction-memory port and core start handshake.
// Optional handshake watchdog enabled by defining CICERO_CMD_TIMEOUT_EN.
module cicero_cmd_ctrl
  import cicero_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] command,
  input  logic [31:0] address,
  input  logic [31:0] start_cc_pointer,
  input  logic [31:0] end_cc_pointer,
  input  logic [63:0] data_in,
  output logic [31:0] status,
  output logic [63:0] data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        core_start,
  output logic [31:0] core_start_cc,
  output logic [31:0] core_end_cc,
  input  logic        core_accept,
  output logic        core_reset,
  input  logic        core_running
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [31:0] cmd_sync, cmd_prev, addr_sync, scc_sync, ecc_sync;
  logic [63:0] din_sync;

  cdc_sync_bus #(.W(32)) u_sync_cmd  (.clk(clk), .rst_n(rst_n), .d(command),          .q(cmd_sync));
  cdc_sync_bus #(.W(32)) u_sync_addr (.clk(clk), .rst_n(rst_n), .d(address),          .q(addr_sync));
  cdc_sync_bus #(.W(32)) u_sync_scc  (.clk(clk), .rst_n(rst_n), .d(start_cc_pointer), .q(scc_sync));
  cdc_sync_bus #(.W(32)) u_sync_ecc  (.clk(clk), .rst_n(rst_n), .d(end_cc_pointer),   .q(ecc_sync));
  cdc_sync_bus #(.W(64)) u_sync_din  (.clk(clk), .rst_n(rst_n), .d(data_in),          .q(din_sync));

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, last_tag;
  logic [OP_W-1:0]   op_q;
  logic [ERR_W-1:0]  pend_err, err_code;
  logic              sticky, busy_q, run_q;
  logic              detect_c, timeout_c, tmo_hit_c;

  // Previous synchronized command for the stability filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_prev <= '0;
    else        cmd_prev <= cmd_sync;
  end

  assign detect_c = (state_q == ST_IDLE) && (cmd_sync == cmd_prev) &&
                    (cmd_sync[31:24] != last_tag);

`ifdef CICERO_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt;

  // Cycles spent waiting in the current handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if ((state_q == ST_MEM || state_q == ST_START) && state_d == state_q)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  assign timeout_c = (state_q == ST_MEM || state_q == ST_START) &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; an ack in the same cycle as the watchdog limit wins.
  always_comb begin
    state_d   = state_q;
    tmo_hit_c = 1'b0;
    case (state_q)
      ST_IDLE:   if (detect_c) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_q)
          OP_WRITE, OP_READ: state_d = ST_MEM;
          OP_START:          state_d = ST_START;
          default:           state_d = ST_DONE;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) state_d = ST_DONE;
        else if (timeout_c) begin
          state_d   = ST_DONE;
          tmo_hit_c = 1'b1;
        end
      end
      ST_START: begin
        if (core_accept) state_d = ST_DONE;
        else if (timeout_c) begin
          state_d   = ST_DONE;
          tmo_hit_c = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operand capture, handshake outputs, read data and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q         <= '0;
      op_q          <= OP_NOP;
      pend_err      <= ERR_NONE;
      last_tag      <= '0;
      err_code      <= ERR_NONE;
      sticky        <= 1'b0;
      busy_q        <= 1'b0;
      run_q         <= 1'b0;
      data_out      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      core_start    <= 1'b0;
      core_start_cc <= '0;
      core_end_cc   <= '0;
      core_reset    <= 1'b0;
    end else begin
      busy_q     <= (state_d != ST_IDLE);
      run_q      <= core_running;
      mem_req    <= (state_d == ST_MEM);
      mem_we     <= (state_d == ST_MEM) && (op_q == OP_WRITE);
      core_start <= (state_d == ST_START);
      core_reset <= (state_q == ST_DECODE) && (op_q == OP_CORE_RESET);

      if (detect_c) begin
        tag_q         <= cmd_sync[31:24];
        op_q          <= cmd_sync[3:0];
        mem_addr      <= addr_sync;
        mem_wdata     <= din_sync;
        core_start_cc <= scc_sync;
        core_end_cc   <= ecc_sync;
        pend_err      <= ERR_NONE;
      end

      if (state_q == ST_DECODE && op_q > OP_CLEAR_ERR)
        pend_err <= ERR_ILLEGAL;

      if (tmo_hit_c)
        pend_err <= (state_q == ST_START) ? ERR_START_TIMEOUT : ERR_MEM_TIMEOUT;

      if (state_q == ST_MEM && mem_ack && op_q == OP_READ)
        data_out <= mem_rdata;

      if (state_q == ST_DONE) begin
        last_tag <= tag_q;
        if (pend_err != ERR_NONE) begin
          err_code <= pend_err;
          sticky   <= 1'b1;
        end else if (op_q == OP_CLEAR_ERR) begin
          err_code <= ERR_NONE;
          sticky   <= 1'b0;
        end
      end
    end
  end

  // Status word assembled from registered fields only.
  always_comb begin
    status = '0;
    status[ST_TAG_LSB +: TAG_W]     = last_tag;
    status[ST_STATE_LSB +: STATE_W] = state_q;
    status[ST_ERR_LSB +: ERR_W]     = err_code;
    status[ST_RUN_BIT]              = run_q;
    status[ST_STICKY_BIT]           = sticky;
    status[ST_BUSY_BIT]             = busy_q;
  end

endmodule

// File: tb/tb_cicero_cmd_ctrl.sv
// Directed self-checking bench for cicero_cmd_ctrl with a transaction-level model.
module tb_cicero_cmd_ctrl;

`ifdef CICERO_CMD_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] command, address, start_cc_pointer, end_cc_pointer;
  logic [63:0] data_in;
  logic [31:0] status;
  logic [63:0] data_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        core_start, core_accept, core_reset, core_running;
  logic [31:0] core_start_cc, core_end_cc;

  cicero_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .address(address),
    .start_cc_pointer(start_cc_pointer), .end_cc_pointer(end_cc_pointer),
    .data_in(data_in), .status(status), .data_out(data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .core_start(core_start),
    .core_start_cc(core_start_cc), .core_end_cc(core_end_cc),
    .core_accept(core_accept), .core_reset(core_reset), .core_running(core_running)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int req_rises = 0;
  int rst_pulses = 0;
  bit settled = 1'b0;
  logic prev_req = 1'b0;

  // Transaction-level model of the controller's visible state.
  logic [7:0]  m_last_tag = 8'h00;
  logic [3:0]  m_err = 4'h0;
  logic        m_sticky = 1'b0;
  logic [63:0] m_data = 64'h0;
  logic [31:0] m_addr, m_scc, m_ecc;
  logic [63:0] m_wdata;
  logic        m_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && !prev_req) req_rises++;
      if (core_reset) rst_pulses++;
      if (mem_req) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_we);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("req_excl", core_start, 1'b0);
      end
      if (core_start) begin
        chk("core_start_cc", core_start_cc, m_scc);
        chk("core_end_cc", core_end_cc, m_ecc);
      end
      if (settled) begin
        chk("idle_status", status, {m_last_tag, 4'h0, m_err, 13'h0, 1'b0, m_sticky, 1'b0});
        chk("idle_data_out", data_out, m_data);
        chk("idle_mem_req", mem_req, 1'b0);
        chk("idle_core_start", core_start, 1'b0);
      end
    end
    prev_req = mem_req;
  end

  task automatic set_ops(input logic [31:0] a, input logic [63:0] d,
                         input logic [31:0] s, input logic [31:0] e);
    address = a; data_in = d; start_cc_pointer = s; end_cc_pointer = e;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Issue one command; ack_dly < 0 means never acknowledge.
  task automatic issue(input logic [31:0] cmd, input int ack_dly, input logic [63:0] rd);
    int n;
    int req0;
    logic [3:0] op;
    bit tmo;
    op = cmd[3:0];
    tmo = 1'b0;
    req0 = req_rises;
    settled = 1'b0;
    m_addr = address; m_wdata = data_in; m_we = (op == 4'd1);
    m_scc = start_cc_pointer; m_ecc = end_cc_pointer;
    mem_rdata = rd;
    command = cmd;
    if (cmd[31:24] == m_last_tag) begin
      repeat (12) @(posedge clk);
      #1;
      chk("ignored_no_req", 64'(req_rises - req0), 64'd0);
      chk("ignored_not_busy", status[0], 1'b0);
      settled = 1'b1;
      return;
    end
    n = 0;
    while (status[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("busy_latency", 64'(n), 64'd4);
    if (op == 4'd1 || op == 4'd2 || op == 4'd3) begin
      n = 0;
      while (((op == 4'd3) ? core_start : mem_req) !== 1'b1 && n < 4) begin
        @(posedge clk); #1; n++;
      end
      chk("req_latency", 64'(n), 64'd1);
      if (ack_dly < 0) begin
        n = 0;
        while (((op == 4'd3) ? core_start : mem_req) === 1'b1 && n < TMO + 4) begin
          @(posedge clk); #1; n++;
        end
        chk("tmo_req_cycles", 64'(n), 64'(TMO));
        tmo = 1'b1;
      end else begin
        repeat (ack_dly) @(posedge clk);
        #1;
        chk("req_held", (op == 4'd3) ? core_start : mem_req, 1'b1);
        if (op == 4'd3) core_accept = 1'b1; else mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0; core_accept = 1'b0;
        chk("req_drop", (op == 4'd3) ? core_start : mem_req, 1'b0);
      end
    end
    n = 0;
    while (status[0] === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("busy_release", status[0], 1'b0);
    m_last_tag = cmd[31:24];
    if (tmo) begin
      m_err = (op == 4'd3) ? 4'h3 : 4'h2;
      m_sticky = 1'b1;
    end else if (op == 4'd2) m_data = rd;
    else if (op == 4'd5) begin m_err = 4'h0; m_sticky = 1'b0; end
    else if (op > 4'd5) begin m_err = 4'h1; m_sticky = 1'b1; end
    chk("done_status", status, {m_last_tag, 4'h0, m_err, 13'h0, 1'b0, m_sticky, 1'b0});
    settled = 1'b1;
  endtask

  initial begin
    int p0;
    int n;
    rst_n = 1'b0;
    command = 32'h0; address = 32'h0; start_cc_pointer = 32'h0; end_cc_pointer = 32'h0;
    data_in = 64'h0; mem_ack = 1'b0; mem_rdata = 64'h0; core_accept = 1'b0; core_running = 1'b0;
    #12;
    chk("rst_status", status, 64'h0);
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_reset", core_reset, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    settled = 1'b1;

    issue(32'h0000_0000, 0, 64'h0);
    chk("tag0_status", status, 64'h0);

    set_ops(32'h10, 64'h1122_3344_5566_7788, 32'h0, 32'h0);
    issue(32'h0100_0001, 0, 64'h0);
    chk("write_tag", status[31:24], 8'h01);

    issue(32'h0200_0002, 5, 64'hDEAD_BEEF_0000_0001);
    chk("read_data", data_out, 64'hDEAD_BEEF_0000_0001);
    chk("read_tag", status[31:24], 8'h02);

    set_ops(32'h10, 64'h1122_3344_5566_7788, 32'd4, 32'd40);
    issue(32'h0300_0003, 3, 64'h0);
    chk("start_cc", core_start_cc, 64'd4);
    chk("end_cc", core_end_cc, 64'd40);

    issue(32'h0400_0009, 0, 64'h0);
    chk("illegal_err", status[19:16], 4'h1);
    chk("illegal_sticky", status[1], 1'b1);

    issue(32'h0500_0005, 0, 64'h0);
    chk("clear_status", status, 64'h0500_0000);
    issue(32'h0500_0009, 0, 64'h0);
    chk("dup_tag_no_err", status[19:16], 4'h0);

    p0 = rst_pulses;
    issue(32'h0700_0004, 0, 64'h0);
    chk("core_reset_pulse", 64'(rst_pulses - p0), 64'd1);

    issue(32'h0800_0000, 0, 64'h0);

    settled = 1'b0;
    core_running = 1'b1;
    @(posedge clk); #1;
    chk("running_bit", status[2], 1'b1);
    core_running = 1'b0;
    @(posedge clk); #1;
    chk("running_clr", status[2], 1'b0);
    settled = 1'b1;

`ifdef CICERO_CMD_TIMEOUT_EN
    set_ops(32'h20, 64'hA5A5_0000_5A5A_FFFF, 32'd8, 32'd9);
    issue(32'h0900_0001, -1, 64'h0);
    chk("mem_tmo_err", status[19:16], 4'h2);
    issue(32'h0A00_0005, 0, 64'h0);
    issue(32'h0B00_0003, -1, 64'h0);
    chk("start_tmo_err", status[19:16], 4'h3);
    issue(32'h0C00_0005, 0, 64'h0);
`endif

    set_ops(32'h30, 64'h0BAD_F00D_1234_5678, 32'd1, 32'd2);
    settled = 1'b0;
    m_addr = address; m_wdata = data_in; m_we = 1'b1;
    command = 32'h0D00_0001;
    n = 0;
    while (mem_req !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
    chk("mid_req_seen", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_status", status, 64'h0);
    chk("async_rst_start", core_start, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule
